disp_scan_sched: RTL
====================

# disp_scan_sched

Scan controller and display arbiter for the 4-digit multiplexed seven-segment display.
- Divides the system clock into a digit-scan tick and steps through the four digits.
- Inserts blanking gaps between digits to suppress ghosting.
- Shares the display between several 16-bit requesters (operand A, operand B, result) using round-robin arbitration with a minimum dwell time.
- Drives the existing segment decoder through `sel`/`nibble` and the digit cathodes through `cat`.

## Interface
Parameters:
- CLK_DIV, 50000: clk cycles each digit is lit (SCAN phase); must be ≥2.
- BLANK_CYC, 4: clk cycles of all-off between digits; 0 means no blanking.
- DWELL_FRAMES, 64: minimum frames a granted requester holds the display while others wait; must be ≥1.
- NREQ, 3: number of requesters; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester display request, level.
- word  in  NREQ*16  requester i data at word[16*i+15:16*i].
- grant  out  NREQ  one-hot current owner; all-zero means no owner.
- sel  out  2  current digit index, 0 = leftmost.
- cat  out  4  digit enables, one-hot: sel 0→1000, 1→0100, 2→0010, 3→0001; 0000 while blanked.
- nibble  out  4  hex digit for sel: sel 0→word[15:12] … sel 3→word[3:0] of the latched word.
- frame_done  out  1  one-cycle pulse per completed 4-digit frame.

## Operation
- Prescaler counts clk cycles within the current phase.
- Digit FSM states:
  - SCAN: cat asserted for sel.
  - BLANK: cat = 0000, sel unchanged.
- Transitions:
  - SCAN→BLANK after CLK_DIV cycles.
  - BLANK→SCAN after BLANK_CYC cycles; sel increments on this transition (3 wraps to 0).
  - BLANK_CYC = 0: SCAN→SCAN directly with sel increment.
- Frame boundary: the edge on which sel wraps 3→0.
- At each frame boundary, all of the following happen on that edge:
  - frame_done pulses high for the following cycle.
  - The arbiter decides the owner.
  - The owner's word is latched into the display register.
- Display content never changes mid-frame, even if `word` or `req` changes.
- Arbitration at a frame boundary:
  - Owner retained if its req is high and its dwell count < DWELL_FRAMES.
  - Otherwise: round-robin search starting at owner+1 (index 0 after reset); the first requester with req high wins, and the dwell count resets to 1.
  - Owner retained past dwell if no other req is high; dwell count saturates at DWELL_FRAMES.
  - No req high: grant = 0, latched word holds its last value, scanning continues.
- An owner that drops req mid-frame keeps grant until the next frame boundary.

## Timing
- Reset values: state SCAN, sel = 0, cat = 1000, nibble = 0, grant = 0, frame_done = 0, latched word = 0x0000, dwell = 0, RR pointer = 0, prescaler = 0.
- All outputs are registered. nibble and cat change on the same edge as sel.
- Frame period is 4·(CLK_DIV+BLANK_CYC) clk cycles.
- First arbitration occurs at the first frame boundary after reset release.
- Reset asserted mid-operation, including during BLANK: outputs take reset values immediately (asynchronous); scanning restarts at sel 0 after release.

## Configuration
- DISP_LZ_BLANK_EN defined (leading-zero blanking):
  - During SCAN, cat is forced to 0000 for any digit 0..2 whose nibble and all more-significant nibbles of the latched word are zero.
  - Digit 3 is always lit.
  - sel and nibble are unaffected.
- DISP_LZ_BLANK_EN undefined: every digit is lit in SCAN regardless of value.

## Structure
- Shared package disp_pkg:
  - DIGITS = 4.
  - Cathode one-hot constants CAT_D0..CAT_D3 and CAT_OFF.
  - Scan state enum {SCAN, BLANK}.
- Sub-module rr_arbiter:
  - Contains the round-robin pointer and the dwell counter.
  - Parameterised by NREQ and DWELL_FRAMES.
  - Evaluates on a frame-boundary strobe input.
- Scan FSM, prescaler, word latch and LZ logic live in disp_scan_sched.

## Test plan
Bench parameters: CLK_DIV=4, BLANK_CYC=2, DWELL_FRAMES=2, NREQ=3.
- Release reset, req=000 → each sel 0..3 has 4 cycles of one-hot cat then 2 cycles of cat=0000; frame_done every 24 cycles; grant stays 000.
- req=001, word0=0x1234 → after the first frame_done, grant=001 and nibble reads 1,2,3,4 on sel 0..3.
- req=011 held → grant 001 for 2 frames, 010 for 2 frames, then alternates; req=010 alone → 010 held indefinitely.
- Owner changes word0 and drops req mid-frame → remaining digits show the old word; grant changes only at the frame boundary.
- Assert reset during BLANK of sel 2 → same cycle sel=0, cat=1000, grant=000, nibble=0.
- word0=0x0042 granted → with DISP_LZ_BLANK_EN, cat=0000 during SCAN of sel 0 and 1, 0010/0001 for sel 2/3; without the macro, all four digits are lit.

Source files
------------

// File: rtl/disp_scan_sched_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Package disp_pkg: digit count, cathode one-hot codes, scan state enum,
// and small helpers for cathode/nibble selection and leading-zero masking.
package disp_pkg;

   localparam int DIGITS = 4;

   localparam logic [3:0] CAT_D0  = 4'b1000;
   localparam logic [3:0] CAT_D1  = 4'b0100;
   localparam logic [3:0] CAT_D2  = 4'b0010;
   localparam logic [3:0] CAT_D3  = 4'b0001;
   localparam logic [3:0] CAT_OFF = 4'b0000;

   typedef enum logic [0:0] {
      SCAN  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

   // One-hot cathode pattern for a digit index (0 = leftmost).
   function automatic logic [3:0] cat_for_sel(input logic [1:0] sel_v);
      logic [3:0] c;
      case (sel_v)
         2'd0:    c = CAT_D0;
         2'd1:    c = CAT_D1;
         2'd2:    c = CAT_D2;
         2'd3:    c = CAT_D3;
         default: c = CAT_OFF;
      endcase
      return c;
   endfunction

   // Hex digit shown at a digit index; digit 0 is the most significant nibble.
   function automatic logic [3:0] nibble_for_sel(input logic [15:0] w, input logic [1:0] sel_v);
      logic [3:0] n;
      case (sel_v)
         2'd0:    n = w[15:12];
         2'd1:    n = w[11:8];
         2'd2:    n = w[7:4];
         2'd3:    n = w[3:0];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

   // Cathode enable mask that suppresses leading zeros; the last digit always stays lit.
   function automatic logic [3:0] lz_mask(input logic [15:0] w);
      logic [3:0] m;
      m[3] = (w[15:12] != 4'h0);
      m[2] = (w[15:8]  != 8'h00);
      m[1] = (w[15:4]  != 12'h000);
      m[0] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/disp_scan_sched_if.sv
// Requester/display bus of the scan scheduler.
// master: the side that raises requests and watches the display outputs.
// slave:  the scheduler itself.
interface disp_scan_sched_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req;
   logic [NREQ*16-1:0] word;
   logic [NREQ-1:0]    grant;
   logic [1:0]         sel;
   logic [3:0]         cat;
   logic [3:0]         nibble;
   logic               frame_done;

   modport master (
      output req, word,
      input  grant, sel, cat, nibble, frame_done
   );

   modport slave (
      input  req, word,
      output grant, sel, cat, nibble, frame_done
   );
endinterface

// File: rtl/disp_scan_sched_rr_arbiter.sv
// Round-robin display arbiter with minimum dwell, evaluated once per frame.
// The decision for the coming frame is exposed combinationally (win_vld/win_idx)
// so the parent can latch the winner's word on the same edge grant updates.
module rr_arbiter
   import disp_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int DWELL_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         grant,
   output logic                    win_vld,
   output logic [$clog2(NREQ)-1:0] win_idx
);
   localparam int IW = $clog2(NREQ);
   localparam int DW = $clog2(DWELL_FRAMES + 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES);
   localparam logic [IW:0]   NREQ_W    = (IW + 1)'(NREQ);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

   logic [IW-1:0]   ptr_r, ptr_nxt_s;
   logic [IW-1:0]   owner_r;
   logic            own_vld_r;
   logic [DW-1:0]   dwell_r, dwell_nxt_s;
   logic [NREQ-1:0] grant_r, grant_nxt_s;
   logic            keep_s, found_s;
   logic [IW-1:0]   hit_idx_s, idx_s;
   logic [IW:0]     sum_s;

   // Decide the next owner: keep the current one while dwell allows, else search from the pointer.
   always_comb begin
      keep_s    = own_vld_r && req[owner_r] && (dwell_r < DWELL_MAX);
      found_s   = 1'b0;
      hit_idx_s = '0;
      sum_s     = '0;
      idx_s     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_s = {1'b0, ptr_r} + (IW + 1)'(k);
         if (sum_s >= NREQ_W) begin
            sum_s = sum_s - NREQ_W;
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IW-1:0];
         if (!found_s && req[idx_s]) begin
            found_s   = 1'b1;
            hit_idx_s = idx_s;
         end else begin
            found_s   = found_s;
         end
      end
      if (keep_s) begin
         win_vld = 1'b1;
         win_idx = owner_r;
      end else if (found_s) begin
         win_vld = 1'b1;
         win_idx = hit_idx_s;
      end else begin
         win_vld = 1'b0;
         win_idx = '0;
      end
   end

   // Derive next grant, dwell count and search pointer from the decision.
   always_comb begin
      grant_nxt_s = '0;
      dwell_nxt_s = '0;
      ptr_nxt_s   = ptr_r;
      if (win_vld) begin
         grant_nxt_s = NREQ'(1) << win_idx;
         if (own_vld_r && (win_idx == owner_r)) begin
            dwell_nxt_s = (dwell_r < DWELL_MAX) ? (dwell_r + DW'(1)) : DWELL_MAX;
         end else begin
            dwell_nxt_s = DW'(1);
         end
         if (win_idx == LAST_IDX) begin
            ptr_nxt_s = '0;
         end else begin
            ptr_nxt_s = win_idx + IW'(1);
         end
      end else begin
         grant_nxt_s = '0;
         dwell_nxt_s = '0;
         ptr_nxt_s   = ptr_r;
      end
   end

   // Commit the arbitration result only on the frame-boundary strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_r   <= '0;
         owner_r   <= '0;
         own_vld_r <= 1'b0;
         dwell_r   <= '0;
         ptr_r     <= '0;
      end else if (frame_tick) begin
         grant_r   <= grant_nxt_s;
         owner_r   <= win_idx;
         own_vld_r <= win_vld;
         dwell_r   <= dwell_nxt_s;
         ptr_r     <= ptr_nxt_s;
      end else begin
         grant_r   <= grant_r;
         owner_r   <= owner_r;
         own_vld_r <= own_vld_r;
         dwell_r   <= dwell_r;
         ptr_r     <= ptr_r;
      end
   end

   assign grant = grant_r;

endmodule

// File: rtl/disp_scan_sched.sv
// Scan controller and display arbiter for a 4-digit multiplexed 7-seg display.
// Each digit is lit for CLK_DIV cycles, followed by BLANK_CYC all-off cycles.
// At each frame boundary (sel wrapping 3->0) the arbiter picks an owner and its
// word is latched, so content never changes within a frame.
// Optional build macro: DISP_LZ_BLANK_EN enables leading-zero blanking.
module disp_scan_sched
   import disp_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYC    = 4,
   parameter int DWELL_FRAMES = 64,
   parameter int NREQ         = 3
) (
   input logic              clk,
   input logic              reset,
   disp_scan_sched_if.slave bus
);
   localparam int PHASE_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
   localparam int CW        = $clog2(PHASE_MAX + 1);
   localparam int IW        = $clog2(NREQ);
   localparam bit BLANK_EN  = (BLANK_CYC > 0);
   localparam logic [CW-1:0] SCAN_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
   localparam logic [1:0]    LAST_SEL   = 2'(DIGITS - 1);

   scan_state_t     state_r, state_nxt_s;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic [1:0]      sel_r, sel_nxt_s;
   logic            frame_tick_s;
   logic [15:0]     disp_word_r, disp_word_nxt_s, sel_word_s;
   logic [3:0]      cat_r, cat_nxt_s;
   logic [3:0]      nibble_r, nibble_nxt_s;
   logic            frame_done_r;
   logic [NREQ-1:0] grant_s;
   logic            win_vld_s;
   logic [IW-1:0]   win_idx_s;

   rr_arbiter #(
      .NREQ         (NREQ),
      .DWELL_FRAMES (DWELL_FRAMES)
   ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick_s),
      .req        (bus.req),
      .grant      (grant_s),
      .win_vld    (win_vld_s),
      .win_idx    (win_idx_s)
   );

   // Scan state register: phase, prescaler and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= SCAN;
         cnt_r   <= '0;
         sel_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         sel_r   <= sel_nxt_s;
      end
   end

   // Next scan state: SCAN for CLK_DIV cycles, then BLANK (if any), then next digit.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r + CW'(1);
      sel_nxt_s    = sel_r;
      frame_tick_s = 1'b0;
      case (state_r)
         SCAN: begin
            if (cnt_r == SCAN_LAST) begin
               cnt_nxt_s = '0;
               if (BLANK_EN) begin
                  state_nxt_s = BLANK;
               end else begin
                  sel_nxt_s    = sel_r + 2'd1;
                  frame_tick_s = (sel_r == LAST_SEL);
               end
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               cnt_nxt_s    = '0;
               state_nxt_s  = SCAN;
               sel_nxt_s    = sel_r + 2'd1;
               frame_tick_s = (sel_r == LAST_SEL);
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_nxt_s = SCAN;
            cnt_nxt_s   = '0;
            sel_nxt_s   = 2'd0;
         end
      endcase
   end

   // Pick the winning requester's word out of the packed word bus.
   always_comb begin
      sel_word_s = 16'h0000;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx_s == IW'(i)) begin
            sel_word_s = bus.word[16*i +: 16];
         end else begin
            sel_word_s = sel_word_s;
         end
      end
   end

   // Output decode from the next-state values so sel, cat and nibble move together.
   always_comb begin
      if (frame_tick_s && win_vld_s) begin
         disp_word_nxt_s = sel_word_s;
      end else begin
         disp_word_nxt_s = disp_word_r;
      end
      nibble_nxt_s = nibble_for_sel(disp_word_nxt_s, sel_nxt_s);
      if (state_nxt_s == SCAN) begin
`ifdef DISP_LZ_BLANK_EN
         cat_nxt_s = cat_for_sel(sel_nxt_s) & lz_mask(disp_word_nxt_s);
`else
         cat_nxt_s = cat_for_sel(sel_nxt_s);
`endif
      end else begin
         cat_nxt_s = CAT_OFF;
      end
   end

   // Registered outputs and the latched display word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_word_r  <= 16'h0000;
         cat_r        <= CAT_D0;
         nibble_r     <= 4'h0;
         frame_done_r <= 1'b0;
      end else begin
         disp_word_r  <= disp_word_nxt_s;
         cat_r        <= cat_nxt_s;
         nibble_r     <= nibble_nxt_s;
         frame_done_r <= frame_tick_s;
      end
   end

   assign bus.grant      = grant_s;
   assign bus.sel        = sel_r;
   assign bus.cat        = cat_r;
   assign bus.nibble     = nibble_r;
   assign bus.frame_done = frame_done_r;

endmodule
